shift_request_queue: RTL and testbench

//  Upstream issue stage for the 8-bit barrel_shifter (combinational).
//  - Buffers shift requests {data, amount, direction} in a small FIFO.
//  - Issues one request per cycle to the shifter through registered sh_* ports.
//  - Captures sh_result into a result register that has its own valid/ready output.
//  - Turns the combinational shifter into a flow-controlled, back-pressurable pipeline stage.

---
 rtl/shift_request_queue.sv | 113 +++++++++++
 tb/tb_shift_request_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_request_queue.sv
// Issue stage for a combinational barrel shifter: request FIFO -> registered sh_* -> result register.
// Optional build macro SHQ_DONE_CNT_EN adds a 16-bit done_count of output handshakes.
module shift_request_queue #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SHW   = $clog2(WIDTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  input  logic             in_dir,
  output logic [WIDTH-1:0] sh_data,
  output logic [SHW-1:0]   sh_amount,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amount,
  output logic             out_dir,
  output logic [AW:0]      fifo_count
`ifdef SHQ_DONE_CNT_EN
  ,
  output logic [15:0]      done_count
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amount;
    logic             dir;
  } req_t;

  req_t        mem [DEPTH];
  req_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        push, pop, s2_take;
  logic        issue_vld;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty      = (wr_ptr == rd_ptr);
  assign fifo_count = wr_ptr - rd_ptr;
  assign in_ready   = !full;
  assign head       = mem[rd_ptr[AW-1:0]];

  assign push    = in_valid && in_ready;
  assign s2_take = issue_vld && (!out_valid || out_ready);
  assign pop     = !empty && (!issue_vld || s2_take);

  // NOTE: the storage array has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_data, in_amount, in_dir};
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Stage 1: sh_* only change when the slot is empty or stage 2 is draining it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_vld <= 1'b0;
      sh_data   <= '0;
      sh_amount <= '0;
      sh_dir    <= 1'b0;
    end else if (pop) begin
      issue_vld <= 1'b1;
      sh_data   <= head.data;
      sh_amount <= head.amount;
      sh_dir    <= head.dir;
    end else if (s2_take) begin
      issue_vld <= 1'b0;
    end
  end

  // Stage 2: result register with the request's amount/dir carried along as a tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_amount <= '0;
      out_dir    <= 1'b0;
    end else if (s2_take) begin
      out_valid  <= 1'b1;
      out_data   <= sh_result;
      out_amount <= sh_amount;
      out_dir    <= sh_dir;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef SHQ_DONE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      done_count <= '0;
    else if (out_valid && out_ready) done_count <= done_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_shift_request_queue.sv
// Self-checking bench for shift_request_queue with a behavioural barrel shifter on sh_*.
// Expected results come from an arithmetic shift model and an in-order scoreboard queue.
module tb_shift_request_queue;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SHW   = 3;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_dir;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amount;
  logic [WIDTH-1:0] sh_data, sh_result;
  logic [SHW-1:0]   sh_amount;
  logic             sh_dir;
  logic             out_valid, out_ready, out_dir;
  logic [WIDTH-1:0] out_data;
  logic [SHW-1:0]   out_amount;
  logic [AW:0]      fifo_count;
`ifdef SHQ_DONE_CNT_EN
  logic [15:0]      done_count;
`endif

  shift_request_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amount(in_amount), .in_dir(in_dir),
    .sh_data(sh_data), .sh_amount(sh_amount), .sh_dir(sh_dir), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_amount(out_amount), .out_dir(out_dir), .fifo_count(fifo_count)
`ifdef SHQ_DONE_CNT_EN
    , .done_count(done_count)
`endif
  );

  // Logical barrel shifter between sh_* and sh_result.
  assign sh_result = sh_dir ? (sh_data >> sh_amount) : (sh_data << sh_amount);

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [SHW-1:0]   amt;
    logic             dir;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] got_q[$];
  int               got_cyc[$];
  int               checks = 0, failures = 0;
  int               cyc = 0, push_cnt = 0, done_ref = 0;

  function automatic logic [WIDTH-1:0] shift_ref(input logic [WIDTH-1:0] d,
                                                  input logic [SHW-1:0] a, input logic r);
    int v, p;
    v = int'(d);
    p = 1 << a;
    return r ? WIDTH'(v / p) : WIDTH'((v * p) % (1 << WIDTH));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Handshakes are observed mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else begin
          e = sb.pop_front();
          check("out_data",   32'(out_data),   32'(e.res));
          check("out_amount", 32'(out_amount), 32'(e.amt));
          check("out_dir",    32'(out_dir),    32'(e.dir));
        end
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
        done_ref++;
      end
      if (in_valid && in_ready) begin
        e.res = shift_ref(in_data, in_amount, in_dir);
        e.amt = in_amount;
        e.dir = in_dir;
        sb.push_back(e);
        push_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a, input logic r);
    in_data = d; in_amount = a; in_dir = r;
  endtask

  task automatic drive_rand();
    drive(WIDTH'($urandom), SHW'($urandom), 1'($urandom));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_in_ready"},   32'(in_ready),   32'd1);
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_sh_data"},    32'(sh_data),    32'd0);
    check({tag, "_sh_amount"},  32'(sh_amount),  32'd0);
    check({tag, "_sh_dir"},     32'(sh_dir),     32'd0);
    check({tag, "_out_data"},   32'(out_data),   32'd0);
`ifdef SHQ_DONE_CNT_EN
    check({tag, "_done_count"}, 32'(done_count), 32'd0);
`endif
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    sb.delete(); got_q.delete(); got_cyc.delete();
    done_ref = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic fill_pipe(output int accepted);
    int start;
    start = push_cnt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      step();
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    accepted = push_cnt - start;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (sb.size() != 0 || out_valid); i++) step();
    check("drain_sb_empty",  32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, start;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] exp3 [4];
    logic [SHW-1:0]   amt3 [4];
    logic             dir3 [4];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive('0, '0, 1'b0);
    #3;
    apply_reset("por");

    // Reset in the middle of traffic discards everything in flight.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(WIDTH'($urandom) | 8'h01, 3'd1, 1'b0);
      step();
    end
    in_valid = 1'b0;
    #1;
    apply_reset("mid");
    out_ready = 1'b1;
    repeat (5) step();
    check("mid_no_output", 32'(got_q.size()), 32'd0);
    check("mid_out_valid", 32'(out_valid),    32'd0);

    // Single request latency: push at edge N, out_valid after N+2.
    drive(8'hAA, 3'd1, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_n0", 32'(out_valid), 32'd0);
    step();
    check("lat_n1", 32'(out_valid), 32'd0);
    step();
    check("lat_n2_valid",  32'(out_valid),  32'd1);
    check("lat_n2_data",   32'(out_data),   32'h55);
    check("lat_n2_amount", 32'(out_amount), 32'd1);
    check("lat_n2_dir",    32'(out_dir),    32'd1);
    step();
    check("lat_after", 32'(out_valid), 32'd0);

    // Streaming: four pushes come out back to back.
    got_q.delete(); got_cyc.delete();
    exp3 = '{8'h55, 8'hA8, 8'h15, 8'hA0};
    amt3 = '{3'd1, 3'd2, 3'd3, 3'd4};
    dir3 = '{1'b1, 1'b0, 1'b1, 1'b0};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'hAA, amt3[i], dir3[i]);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && got_q.size() < 4; i++) step();
    check("stream_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check("stream_data", 32'(got_q[i]), 32'(exp3[i]));
      check("stream_b2b",  32'(got_cyc[i] - got_cyc[0]), 32'(i));
    end
    drain();

    // Backpressure: DEPTH+2 requests in flight, then release.
    fill_pipe(acc);
    check("bp_accepted",   32'(acc),        32'(DEPTH + 2));
    check("bp_fifo_count", 32'(fifo_count), 32'(DEPTH));
    check("bp_in_ready",   32'(in_ready),   32'd0);
    check("bp_out_valid",  32'(out_valid),  32'd1);
    held = sb[0].res;
    repeat (3) step();
    check("bp_hold_data", 32'(out_data), 32'(held));
    got_q.delete(); got_cyc.delete();
    drain();
    check("bp_results", 32'(got_q.size()), 32'(DEPTH + 2));

    // From full: one pop frees a slot, then push and pop every cycle over 3*DEPTH entries.
    fill_pipe(acc);
    check("full_accepted", 32'(acc), 32'(DEPTH + 2));
    start = push_cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_rand();
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      step();
      check("pp_fifo_count", 32'(fifo_count), 32'(DEPTH - 1));
      drive_rand();
    end
    in_valid = 1'b0;
    check("pp_pushes", 32'(push_cnt - start), 32'(3 * DEPTH));
    drain();

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
      step();
      check("rnd_in_ready", 32'(in_ready), 32'(fifo_count != DEPTH));
      check("rnd_inflight", 32'(sb.size() <= DEPTH + 2), 32'd1);
    end
    drain();

`ifdef SHQ_DONE_CNT_EN
    check("done_count", 32'(done_count), 32'(done_ref & 16'hFFFF));
    apply_reset("done_rst");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
